// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator and later MAC stages.
package product_accumulator_pkg;

    localparam int unsigned PROD_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    // 2'd3 is unused; the FSM steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/product_accumulator_acc_sat_add.sv
// Accumulator adder with carry-out; clamps to all-ones or wraps on carry.
module acc_sat_add #(
    parameter int unsigned ACC_W    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum_c,
    output logic             ovf_c
);

    logic [ACC_W:0] full_c;

    always_comb begin
        full_c = {1'b0, acc} + {1'b0, addend};
        ovf_c  = full_c[ACC_W];
        sum_c  = full_c[ACC_W-1:0];
        if (ovf_c && SATURATE) begin
            sum_c = '1;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a frame of multiplier products (terminated by in_last) and hands
// the sum, beat count and overflow flag to a valid/ready consumer.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W   = PROD_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   prod_ext_c;
    logic [ACC_W-1:0]   add_sum_c;
    logic               add_ovf_c;
    logic               in_xfer_c;
    logic               out_xfer_c;

    assign prod_ext_c = ACC_W'(in_product);

    acc_sat_add #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_acc_sat_add (
        .acc    (acc_q),
        .addend (prod_ext_c),
        .sum_c  (add_sum_c),
        .ovf_c  (add_ovf_c)
    );

    // Handshake outputs decoded from the current state; clear and ena gate acceptance.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, ACCUM: in_ready  = ena & ~clear;
            DONE:        out_valid = 1'b1;
            default: ;
        endcase
    end

    assign in_xfer_c  = in_valid & in_ready;
    assign out_xfer_c = out_valid & out_ready & ena & ~clear;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_xfer_c) begin
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer_c && in_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_xfer_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath: first beat loads, later beats add, result drains on out-transfer.
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (in_xfer_c) begin
            if (state_q == IDLE) begin
                acc_d   = prod_ext_c;
                count_d = CNT_W'(1);
                ovf_d   = 1'b0;
            end else begin
                acc_d   = add_sum_c;
                ovf_d   = ovf_q | add_ovf_c;
                count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
            end
        end else if (out_xfer_c) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum      = acc_q;
    assign out_count    = count_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a saturating and a wrapping accumulator with the same beats and checks
// each result against a frame-level arithmetic model.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        in_last;
    logic        out_ready;

    logic        s_in_ready, s_out_valid, s_out_overflow;
    logic [15:0] s_out_sum;
    logic [7:0]  s_out_count;
    logic        w_in_ready, w_out_valid, w_out_overflow;
    logic [15:0] w_out_sum;
    logic [7:0]  w_out_count;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned frame_q[$];

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
        .out_count(s_out_count), .out_overflow(s_out_overflow)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_sum(w_out_sum),
        .out_count(w_out_count), .out_overflow(w_out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offers one beat and returns just after the edge that accepts it.
    task automatic send_beat(input int unsigned p, input bit last);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        in_valid   = 1'b1;
        in_product = 8'(p);
        in_last    = last;
        while (!ok) begin
            @(negedge clk);
            ok = s_in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!ok && guard > 200) begin
                n_cmp++;
                n_err++;
                $error("FAIL beat_timeout observed=stalled expected=accepted");
                ok = 1'b1;
            end
        end
    endtask

    task automatic play_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            send_beat(frame_q[i], i == frame_q.size() - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat; holds off the consumer for 'delay' cycles.
    task automatic check_result(input int delay);
        longint unsigned total;
        int unsigned n, exp_sat, exp_wrap, exp_cnt, exp_ovf;
        total = 0;
        foreach (frame_q[i]) total += frame_q[i];
        n        = frame_q.size();
        exp_sat  = (total > 65535) ? 65535 : 32'(total);
        exp_wrap = 32'(total % 65536);
        exp_cnt  = (n > 255) ? 255 : n;
        exp_ovf  = (total > 65535) ? 1 : 0;
        @(negedge clk);
        chk("sat_out_valid", 32'(s_out_valid), 1);
        chk("wrap_out_valid", 32'(w_out_valid), 1);
        chk("done_in_ready", 32'(s_in_ready), 0);
        chk("sat_out_sum", 32'(s_out_sum), exp_sat);
        chk("wrap_out_sum", 32'(w_out_sum), exp_wrap);
        chk("out_count", 32'(s_out_count), exp_cnt);
        chk("wrap_out_count", 32'(w_out_count), exp_cnt);
        chk("sat_overflow", 32'(s_out_overflow), exp_ovf);
        chk("wrap_overflow", 32'(w_out_overflow), exp_ovf);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(s_out_valid), 1);
            chk("hold_out_sum", 32'(s_out_sum), exp_sat);
            chk("hold_in_ready", 32'(s_in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_out_valid", 32'(s_out_valid), 0);
        chk("post_in_ready", 32'(s_in_ready), 1);
        chk("post_out_sum", 32'(s_out_sum), 0);
        frame_q.delete();
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(s_out_valid), 0);
        chk({tag, "_out_sum"}, 32'(s_out_sum), 0);
        chk({tag, "_out_count"}, 32'(s_out_count), 0);
        chk({tag, "_overflow"}, 32'(s_out_overflow), 0);
        chk({tag, "_wrap_out_valid"}, 32'(w_out_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame
        frame_q = '{15, 63, 225};
        play_frame();
        check_result(0);

        // Long frame: saturation vs wrap, counter clamps at 255
        for (int i = 0; i < 300; i++) frame_q.push_back(225);
        play_frame();
        check_result(0);

        // Backpressure with a pending beat that must not be consumed
        frame_q = '{10, 20};
        play_frame();
        in_valid = 1'b1; in_product = 8'd99; in_last = 1'b1;
        check_result(5);
        in_valid = 1'b0; in_last = 1'b0;

        // Single beat, then the next frame offered during DONE
        frame_q = '{7};
        play_frame();
        in_valid = 1'b1; in_product = 8'd1; in_last = 1'b0;
        check_result(1);
        frame_q = '{1, 2};
        play_frame();
        check_result(0);

        // Abort with clear mid-frame; the beat offered alongside clear is dropped
        send_beat(50, 1'b0);
        send_beat(60, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_product = 8'd99;
        @(negedge clk);
        chk("clear_in_ready", 32'(s_in_ready), 0);
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        check_idle_zero("clear");
        frame_q = '{5};
        play_frame();
        check_result(0);

        // Abort with reset mid-frame
        send_beat(50, 1'b0);
        send_beat(60, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_zero("midrst");
        frame_q = '{5};
        play_frame();
        check_result(0);

        // Enable gating mid-frame and while DONE
        frame_q = '{100, 200, 150, 250};
        send_beat(frame_q[0], 1'b0);
        send_beat(frame_q[1], 1'b0);
        ena = 1'b0; in_valid = 1'b1; in_product = 8'(frame_q[2]); in_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ena_low_in_ready", 32'(s_in_ready), 0);
            @(posedge clk);
            #1;
        end
        ena = 1'b1;
        send_beat(frame_q[2], 1'b0);
        send_beat(frame_q[3], 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        ena = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        ena = 1'b1;
        // The held result is checked as if it had just arrived.
        check_result(0);

        // Random frames, occasionally long enough to overflow
        for (int f = 0; f < 30; f++) begin
            int unsigned len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 320) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) frame_q.push_back($urandom_range(0, 255));
            play_frame();
            check_result(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
